// File: rtl/sipo_pkg.sv
// Shared definitions for the parallel-load shift-register link.
// Used by the receive-side deserializer and its output buffer.
package sipo_pkg;

    localparam int   SIPO_WIDTH = 8;

    localparam logic DIR_LEFT   = 1'b0;
    localparam logic DIR_RIGHT  = 1'b1;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

endpackage

// File: rtl/sipo_out_buf.sv
// Single-word valid/ready holding register between the receiver and its consumer.
// When a completed word arrives while the held word is still pending, the new word is dropped.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   BUF_EMPTY | no word held; data_ready is ignored
//   BUF_FULL  | data_out holds an unconsumed word; data_valid asserted
module sipo_out_buf
    import sipo_pkg::*;
#(
    parameter int WIDTH = SIPO_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             word_done,
    input  logic [WIDTH-1:0] word,
    input  logic             data_ready,
    input  logic             clear_overrun,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             overrun
);

    buf_state_t state_q, state_d;
    logic       load;
    logic       drop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= BUF_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        drop    = 1'b0;
        case (state_q)
            BUF_EMPTY: begin
                if (word_done) begin
                    load    = 1'b1;
                    state_d = BUF_FULL;
                end
            end
            BUF_FULL: begin
                if (data_ready) begin
                    // Accept and refill in the same cycle, so back-to-back words have no bubble.
                    load    = word_done;
                    state_d = word_done ? BUF_FULL : BUF_EMPTY;
                end else if (word_done) begin
                    drop = 1'b1;
                end
            end
            default: state_d = BUF_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out <= '0;
        end else if (load) begin
            data_out <= word;
        end
    end

    // A drop in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (clear_overrun) begin
            overrun <= 1'b0;
        end
    end

    assign data_valid = (state_q == BUF_FULL);

endmodule

// File: rtl/sipo_deserializer_rx.sv
// Receive end of the shift-register link: assembles one serial bit per strobe into a word,
// with per-word bit order, and hands completed words to a one-word valid/ready buffer.
module sipo_deserializer_rx
    import sipo_pkg::*;
#(
    parameter int WIDTH = SIPO_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     sin,
    input  logic                     sin_valid,
    input  logic                     frame_start,
    input  logic                     shift_left_right,
    output logic [WIDTH-1:0]         data_out,
    output logic                     data_valid,
    input  logic                     data_ready,
    output logic [$clog2(WIDTH)-1:0] bit_count,
    output logic                     overrun,
    input  logic                     clear_overrun
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sr_q, sr_d, sr_base;
    logic [CW-1:0]    cnt_q, cnt_d, cnt_base;
    logic             dir_q, dir_d, dir_cur;
    logic             word_done;

    // frame_start restarts the word before the bit on the same cycle is applied.
    always_comb begin
        sr_base   = frame_start ? '0 : sr_q;
        cnt_base  = frame_start ? '0 : cnt_q;
        dir_cur   = (frame_start || cnt_q == '0) ? shift_left_right : dir_q;
        sr_d      = sr_base;
        cnt_d     = cnt_base;
        dir_d     = dir_q;
        word_done = 1'b0;
        if (sin_valid) begin
            dir_d = dir_cur;
            if (dir_cur == DIR_LEFT) begin
                sr_d = {sr_base[WIDTH-2:0], sin};
            end else begin
                sr_d = {sin, sr_base[WIDTH-1:1]};
            end
            if (cnt_base == LAST_BIT) begin
                cnt_d     = '0;
                word_done = 1'b1;
            end else begin
                cnt_d = cnt_base + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr_q  <= '0;
            cnt_q <= '0;
            dir_q <= DIR_LEFT;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
            dir_q <= dir_d;
        end
    end

    assign bit_count = cnt_q;

    sipo_out_buf #(
        .WIDTH (WIDTH)
    ) u_out_buf (
        .clk           (clk),
        .reset_n       (reset_n),
        .word_done     (word_done),
        .word          (sr_d),
        .data_ready    (data_ready),
        .clear_overrun (clear_overrun),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .overrun       (overrun)
    );

endmodule

// File: tb/tb_sipo_deserializer_rx.sv
// Self-checking bench for sipo_deserializer_rx: scenario tasks with a queue of expected words.
module tb_sipo_deserializer_rx;
    import sipo_pkg::*;

    localparam int WIDTH = 8;
    localparam int CW    = $clog2(WIDTH);

    logic             clk              = 1'b0;
    logic             reset_n          = 1'b0;
    logic             sin              = 1'b0;
    logic             sin_valid        = 1'b0;
    logic             frame_start      = 1'b0;
    logic             shift_left_right = 1'b0;
    logic             data_ready       = 1'b0;
    logic             clear_overrun    = 1'b0;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic [CW-1:0]    bit_count;
    logic             overrun;

    int               n_checks = 0;
    int               n_fail   = 0;
    logic [WIDTH-1:0] exp_q[$];

    always #5 clk = ~clk;

    sipo_deserializer_rx #(
        .WIDTH (WIDTH)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .sin              (sin),
        .sin_valid        (sin_valid),
        .frame_start      (frame_start),
        .shift_left_right (shift_left_right),
        .data_out         (data_out),
        .data_valid       (data_valid),
        .data_ready       (data_ready),
        .bit_count        (bit_count),
        .overrun          (overrun),
        .clear_overrun    (clear_overrun)
    );

    task automatic send_bit(input logic b, input logic dir);
        sin              = b;
        shift_left_right = dir;
        sin_valid        = 1'b1;
        @(posedge clk);
        #1;
        sin_valid = 1'b0;
        sin       = 1'b0;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] word, input logic dir, input int gap);
        for (int i = 0; i < WIDTH; i++) begin
            send_bit((dir == DIR_LEFT) ? word[WIDTH-1-i] : word[i], dir);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic consume(input string name);
        int               t;
        logic [WIDTH-1:0] exp;
        t = 0;
        while (data_valid !== 1'b1 && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: word 0x%h presented with no expected word queued", name, data_out);
        end else begin
            exp = exp_q.pop_front();
            if (data_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL %s: timeout, data_valid=%b required 1 (word 0x%h)", name, data_valid, exp);
            end else if (data_out !== exp) begin
                n_fail++;
                $display("FAIL %s: data_out=0x%h required 0x%h", name, data_out, exp);
            end
        end
        data_ready = 1'b1;
        @(posedge clk);
        #1;
        data_ready = 1'b0;
        n_checks++;
        if (data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_release: data_valid=%b required 0", name, data_valid);
        end
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({data_valid, overrun, bit_count, data_out} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b ovr=%b cnt=%0d data=0x%h required all 0",
                     data_valid, overrun, bit_count, data_out);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_word();
        logic seen_valid;
        data_ready = 1'b0;
        send_word(8'h99, DIR_LEFT, 0);
        n_checks++;
        if (data_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_valid: data_valid=%b required 1", data_valid);
        end
        send_bit(1'b1, DIR_LEFT);
        send_bit(1'b0, DIR_LEFT);
        send_bit(1'b1, DIR_LEFT);
        #3;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({data_valid, overrun, bit_count, data_out} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: valid=%b ovr=%b cnt=%0d data=0x%h required all 0",
                     data_valid, overrun, bit_count, data_out);
        end
        #2;
        reset_n = 1'b1;
        seen_valid = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (data_valid !== 1'b0) seen_valid = 1'b1;
        end
        n_checks++;
        if (seen_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: spurious data_valid=%b required 0", seen_valid);
        end
        // Five bits: if the partial word survived reset, this would complete a word.
        for (int i = 0; i < 5; i++) send_bit((i % 2 == 0) ? 1'b1 : 1'b0, DIR_LEFT);
        n_checks++;
        if (data_valid !== 1'b0 || bit_count !== CW'(5)) begin
            n_fail++;
            $display("FAIL post_reset_count: valid=%b cnt=%0d required 0 and 5", data_valid, bit_count);
        end
        exp_q.push_back(8'b10101_011);
        send_bit(1'b0, DIR_LEFT);
        send_bit(1'b1, DIR_LEFT);
        send_bit(1'b1, DIR_LEFT);
        consume("post_reset_word");
    endtask

    task automatic test_msb_first();
        logic [7:0] stream;
        stream = 8'b1010_0101;
        data_ready = 1'b0;
        exp_q.push_back(8'hA5);
        for (int i = 0; i < 8; i++) begin
            send_bit(stream[7-i], DIR_LEFT);
            if (i == 3) begin
                n_checks++;
                if (bit_count !== CW'(4)) begin
                    n_fail++;
                    $display("FAIL msb_mid_count: bit_count=%0d required 4", bit_count);
                end
            end
        end
        n_checks++;
        if (data_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL msb_latency: data_valid=%b required 1 one clock after last bit", data_valid);
        end
        consume("msb_first_A5");
    endtask

    task automatic test_lsb_first();
        logic [7:0] stream;
        data_ready = 1'b0;
        exp_q.push_back(8'hA5);
        send_word(8'hA5, DIR_RIGHT, 0);
        consume("lsb_first_A5");
        stream = 8'b1100_0000;
        exp_q.push_back(8'h03);
        for (int i = 0; i < 8; i++) begin
            send_bit(stream[7-i], (i >= 4) ? DIR_LEFT : DIR_RIGHT);
        end
        consume("lsb_first_03_dir_toggle");
    endtask

    task automatic test_overrun();
        data_ready = 1'b0;
        exp_q.push_back(8'h11);
        send_word(8'h11, DIR_LEFT, 0);
        send_word(8'h22, DIR_LEFT, 0);
        n_checks++;
        if (data_out !== 8'h11 || data_valid !== 1'b1 || overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_drop: data=0x%h valid=%b ovr=%b required 0x11 1 1",
                     data_out, data_valid, overrun);
        end
        clear_overrun = 1'b1;
        @(posedge clk);
        #1;
        clear_overrun = 1'b0;
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_clear: overrun=%b required 0", overrun);
        end
        for (int i = 0; i < 7; i++) send_bit(1'b0, DIR_LEFT);
        clear_overrun = 1'b1;
        send_bit(1'b1, DIR_LEFT);
        clear_overrun = 1'b0;
        n_checks++;
        if (overrun !== 1'b1 || data_out !== 8'h11) begin
            n_fail++;
            $display("FAIL overrun_set_wins: ovr=%b data=0x%h required 1 and 0x11", overrun, data_out);
        end
        clear_overrun = 1'b1;
        @(posedge clk);
        #1;
        clear_overrun = 1'b0;
        consume("overrun_held_word");
    endtask

    task automatic test_stream_ready();
        int               seen;
        logic [WIDTH-1:0] exp;
        seen       = 0;
        data_ready = 1'b1;
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hC3);
        fork
            begin
                send_word(8'h3C, DIR_LEFT, 1);
                send_word(8'hC3, DIR_LEFT, 2);
            end
            begin
                for (int c = 0; c < 120 && seen < 2; c++) begin
                    @(posedge clk);
                    #1;
                    if (data_valid === 1'b1) begin
                        seen++;
                        n_checks++;
                        if (exp_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL stream_extra: word 0x%h presented, none expected", data_out);
                        end else begin
                            exp = exp_q.pop_front();
                            if (data_out !== exp) begin
                                n_fail++;
                                $display("FAIL stream_word: data_out=0x%h required 0x%h", data_out, exp);
                            end
                        end
                    end
                end
            end
        join
        data_ready = 1'b0;
        n_checks++;
        if (seen != 2 || overrun !== 1'b0 || data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_summary: seen=%0d ovr=%b valid=%b required 2 0 0", seen, overrun, data_valid);
        end
        while (exp_q.size() > 0) void'(exp_q.pop_front());
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] exp;
        data_ready = 1'b0;
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'h96);
        send_word(8'h5A, DIR_LEFT, 0);
        for (int i = 0; i < 7; i++) send_bit(exp_q[1][7-i], DIR_LEFT);
        exp = exp_q.pop_front();
        n_checks++;
        if (data_valid !== 1'b1 || data_out !== exp) begin
            n_fail++;
            $display("FAIL b2b_first: valid=%b data=0x%h required 1 0x%h", data_valid, data_out, exp);
        end
        data_ready = 1'b1;
        send_bit(1'b0, DIR_LEFT);
        data_ready = 1'b0;
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_overrun: overrun=%b required 0", overrun);
        end
        consume("b2b_second");
    endtask

    task automatic test_frame_start();
        logic [7:0] word;
        word       = 8'hF0;
        data_ready = 1'b0;
        exp_q.push_back(8'hF0);
        send_bit(1'b0, DIR_LEFT);
        send_bit(1'b1, DIR_LEFT);
        send_bit(1'b1, DIR_LEFT);
        n_checks++;
        if (bit_count !== CW'(3)) begin
            n_fail++;
            $display("FAIL frame_pre_count: bit_count=%0d required 3", bit_count);
        end
        frame_start = 1'b1;
        send_bit(word[7], DIR_LEFT);
        frame_start = 1'b0;
        n_checks++;
        if (bit_count !== CW'(1)) begin
            n_fail++;
            $display("FAIL frame_restart_count: bit_count=%0d required 1", bit_count);
        end
        for (int i = 0; i < 7; i++) begin
            send_bit(word[6-i], DIR_LEFT);
            n_checks++;
            if (bit_count !== CW'((i + 2) % 8)) begin
                n_fail++;
                $display("FAIL frame_count_%0d: bit_count=%0d required %0d", i, bit_count, (i + 2) % 8);
            end
        end
        consume("frame_F0");
    endtask

    initial begin
        test_reset();
        test_reset_mid_word();
        test_msb_first();
        test_lsb_first();
        test_overrun();
        test_stream_ready();
        test_back_to_back();
        test_frame_start();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d words still expected, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
